// File: rtl/arb_mux_pkg.sv
// Shared definitions for the 4:1 arbitrating mux and related 4-way arbiters.
//   ARB_IDLE / ARB_BURST : arbitration FSM states
//   NCH / CH_W           : channel count and channel-index width
//   rr_next()            : round-robin pointer advance with 2-bit wrap
package arb_mux_pkg;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Next round-robin start after serving channel idx.
    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] idx);
        return idx + CH_W'(1);
    endfunction

endpackage

// File: rtl/arb_mux_4_1_rr_pick_4.sv
// Combinational 4-way round-robin picker.
//   req     : request vector, bit i = channel i
//   ptr     : highest-priority channel this cycle
//   gnt_idx : first requester scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   gnt_any : at least one request present
module rr_pick_4
    import arb_mux_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_any
);

    // Rotating scan; first hit wins.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] idx;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            idx = ptr + CH_W'(k);
            if (!found && req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/arb_mux_4_1.sv
// Four-input round-robin arbitrating mux with burst grants and a registered
// output stage. Each output beat carries its source channel in out_sel.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-channel beat valid
//   in_data    : channel i at [i*WIDTH +: WIDTH]
//   in_ready   : per-channel accept (combinational, one-hot or zero)
//   out_valid  : output register holds a beat
//   out_data   : registered beat data
//   out_sel    : source channel of out_data
//   out_ready  : consumer accepts the beat
module arb_mux_4_1
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CH_W-1:0]        out_sel,
    input  logic                   out_ready
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e       state_q, state_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]  out_sel_q, out_sel_d;

    logic [CH_W-1:0]  pick_idx;
    logic             pick_any;
    logic [CH_W-1:0]  sel_idx;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] chan_data [NCH];

    rr_pick_4 u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Unpack the flat input bus into per-channel words.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign slot_free = !out_valid_q || out_ready;

    // Arbitration FSM next state, in_ready and output-register next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        in_ready    = '0;
        sel_idx     = pick_idx;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;

        unique case (state_q)
            ARB_IDLE: begin
                sel_idx = pick_idx;
                if (pick_any && slot_free) begin
                    in_ready[pick_idx] = 1'b1;
                    owner_d            = pick_idx;
                    cnt_d              = CNT_W'(1);
                    if (BURST_LEN == 1) begin
                        ptr_d = rr_next(pick_idx);
                    end else begin
                        state_d = ARB_BURST;
                    end
                end
            end
            ARB_BURST: begin
                sel_idx = owner_q;
                // Backpressure holds the burst; only an idle owner releases it.
                if (slot_free) begin
                    if (in_valid[owner_q]) begin
                        in_ready[owner_q] = 1'b1;
                        cnt_d             = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
                            state_d = ARB_IDLE;
                            ptr_d   = rr_next(owner_q);
                        end
                    end else begin
                        state_d = ARB_IDLE;
                        ptr_d   = rr_next(owner_q);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (rst) begin
            in_ready = '0;
        end

        accept = |in_ready;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[sel_idx];
            out_sel_d   = sel_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/arb_mux_4_1.md
# arb_mux_4_1

Four-input, one-output round-robin arbitrating multiplexer with valid/ready handshakes and a registered output stage. It merges four producer streams into one consumer stream and is the merge-side counterpart of the 1:4 demux path. It tags every output beat with its source index so a downstream 1:4 demux can route responses back. Grants are held for bursts of up to BURST_LEN beats to reduce switching between producers.

## Interface
- WIDTH, 8, data width per channel
- BURST_LEN, 4, maximum consecutive beats granted to one input (≥1)
- clk  input  1  clock, rising edge
- rst  input  1  reset rst, synchronous, active-high
- in_valid  input  4  per-input beat valid; bit i = channel i
- in_data  input  4*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
- in_ready  output  4  per-input accept; one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered beat data
- out_sel  output  2  source channel of the current out_data
- out_ready  input  1  consumer accepts the beat

## Operation
- `slot_free = !out_valid || out_ready`. A beat transfers on an input when `in_valid[i] && in_ready[i]`, and on the output when `out_valid && out_ready`.
- State register: IDLE (no owner) or BURST (owner locked). Also held in registers: `ptr[1:0]` (round-robin start), `owner[1:0]`, and `cnt` (beats issued in the current burst, width clog2(BURST_LEN+1)).
- IDLE:
  - Candidate = first i with in_valid[i] high, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
  - in_ready[candidate] = slot_free.
  - On accept: load the output, owner=candidate, cnt=1.
  - If BURST_LEN==1: ptr=candidate+1 and stay IDLE. Otherwise go to BURST.
- BURST:
  - Only the owner is eligible: in_ready[owner] = slot_free && in_valid[owner].
  - On accept: cnt+1. If the new cnt==BURST_LEN, go to IDLE with ptr=owner+1 (mod 4, 2-bit wrap).
  - If slot_free && !in_valid[owner]: release to IDLE with ptr=owner+1. No beat is issued that cycle (one-cycle bubble).
  - If !slot_free: hold everything (backpressure never releases a burst).
- Output register loads when any in_ready bit fires: out_data ← selected in_data, out_sel ← selected index, out_valid ← 1.
- If the output is consumed and nothing is accepted: out_valid ← 0; out_data and out_sel hold their last values.
- While out_valid && !out_ready: out_data and out_sel are stable and all in_ready = 0.
- in_ready is combinational from in_valid, state, and out_ready. in_ready never depends on in_data.
- No input is starved: every requester is served within 3*BURST_LEN + 3 accepted-or-bubble slot cycles.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, in_ready=0 during rst. Internal state: state=IDLE, ptr=0, owner=0, cnt=0.
- Latency: input acceptance at edge N, so out_valid=1 with that data after edge N.
- Throughput: 1 beat/cycle sustained when out_ready stays high.
- Simultaneous output consume and input accept in the same cycle: the new beat replaces the old with no bubble.
- Reset asserted mid-burst or with out_valid=1: the beat is dropped and all state returns to reset values on that edge. in_ready is 0 during the rst cycle.
- in_valid deasserting without a transfer is a producer protocol violation. The block does not need to handle it beyond re-arbitration.

## Structure
- Shared include/package `arb_mux_pkg`: state encodings ARB_IDLE=1'b0 and ARB_BURST=1'b1, plus channel-count constant NCH=4.
- Sub-module `rr_pick_4`: combinational, inputs req[3:0] and ptr[1:0], outputs gnt_idx[1:0] and gnt_any. Reused by future 4-way arbiters.
- Top level contains the FSM, counters, output register, and data select.

## Test plan
- Reset, then in_valid=4'b0001, in_data[7:0]=8'hA5, out_ready=1 → one cycle later out_valid=1, out_data=A5, out_sel=0. All outputs are 0 during rst.
- All four inputs continuously valid, out_ready=1, BURST_LEN=4 → out_sel sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, with no bubbles.
- Channel 2 valid for 2 beats, then drops, while channel 3 is valid → out_sel is 2,2, then a one-cycle gap, then 3.
- out_ready=0 for 5 cycles with out_valid=1, data=8'h3C → data and sel stay stable and in_ready=0. Release → the next beat follows in the same cycle as the consume.
- BURST_LEN=1, inputs 1 and 3 both valid, ptr=0 → out_sel alternates 1,3,1,3.
- Assert rst mid-burst (cnt=2, owner=1) → after the edge, out_valid=0 and ptr=0. The next grant with all inputs valid goes to channel 0.
